// File: rtl/str_byte_sequencer.sv
// str_byte_sequencer: emits the non-null bytes of a packed string one per
// accepted handshake, skipping null slots, then pulses done for one cycle.
module str_byte_sequencer #(
  parameter int NCHAR = 13
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           load,
  input  logic [NCHAR*8:1]               str_in,
  output logic [7:0]                     out_char,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_last,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(NCHAR+1)-1:0]     char_count
);

  // state | meaning
  // IDLE  | waiting for load; outputs quiet, char_count holds last result
  // SEND  | presenting byte at ptr; null bytes take one skip cycle
  // DONE  | one-cycle end-of-string pulse, then back to IDLE
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int PW = (NCHAR > 1) ? $clog2(NCHAR) : 1;
  localparam int CW = $clog2(NCHAR+1);
  localparam logic [PW-1:0] LAST_PTR = PW'(NCHAR-1);

  state_t            state, state_d;
  logic [NCHAR*8:1]  str_reg;
  logic [PW-1:0]     ptr;
  logic [7:0]        chars [NCHAR];
  logic [7:0]        cur_char;
  logic              tail_zero;
  logic              advance;
  logic              xfer;

  // Unpack the string register into per-slot bytes and find whether
  // everything after the current slot is null.
  always_comb begin
    tail_zero = 1'b1;
    for (int i = 0; i < NCHAR; i++) begin
      chars[i] = str_reg[NCHAR*8-8*i -: 8];
    end
    for (int i = 0; i < NCHAR; i++) begin
      if ((PW'(i) > ptr) && (chars[i] != 8'h00)) tail_zero = 1'b0;
    end
    cur_char = chars[ptr];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next-state and output decode.
  always_comb begin
    state_d   = state;
    out_char  = 8'h00;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    advance   = 1'b0;
    xfer      = 1'b0;
    case (state)
      IDLE: begin
        if (load) state_d = SEND;
      end
      SEND: begin
        busy      = 1'b1;
        out_char  = cur_char;
        out_valid = (cur_char != 8'h00);
        out_last  = out_valid && tail_zero;
        xfer      = out_valid && out_ready;
        // a null slot always moves on; a real byte moves on only when taken
        advance   = !out_valid || out_ready;
        if (advance && (ptr == LAST_PTR)) state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // String capture, position pointer and transfer counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      str_reg    <= '0;
      ptr        <= '0;
      char_count <= '0;
    end else if ((state == IDLE) && load) begin
      str_reg    <= str_in;
      ptr        <= '0;
      char_count <= '0;
    end else if (state == SEND) begin
      if (xfer) char_count <= char_count + CW'(1);
      if (advance && (ptr != LAST_PTR)) ptr <= ptr + PW'(1);
    end
  end

endmodule

// File: tb/tb_str_byte_sequencer.sv
// Scoreboard bench for str_byte_sequencer: a string-level model queues the
// expected bytes and final counts; a negedge monitor checks what the DUT emits.
module tb_str_byte_sequencer;

  localparam int NCHAR = 13;
  localparam int CW = $clog2(NCHAR+1);

  logic                clk = 1'b0;
  logic                rst;
  logic                load;
  logic [NCHAR*8:1]    str_in;
  logic [7:0]          out_char;
  logic                out_valid;
  logic                out_ready;
  logic                out_last;
  logic                busy;
  logic                done;
  logic [CW-1:0]       char_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_chars [$];
  bit         exp_last  [$];
  int         exp_count [$];

  bit         prev_stall = 0;
  logic [7:0] prev_char;
  logic       prev_last;

  str_byte_sequencer #(.NCHAR(NCHAR)) dut (
    .clk(clk), .rst(rst), .load(load), .str_in(str_in),
    .out_char(out_char), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done), .char_count(char_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: compares every handshake and done pulse against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
    end else begin
      check("last_implies_valid", {31'b0, out_last & ~out_valid}, 32'd0);
      if (!busy) check("idle_char_zero", {24'b0, out_char}, 32'd0);
      if (prev_stall) begin
        check("stall_valid_held", {31'b0, out_valid}, 32'd1);
        check("stall_char_held", {24'b0, out_char}, {24'b0, prev_char});
        check("stall_last_held", {31'b0, out_last}, {31'b0, prev_last});
      end
      if (out_valid && out_ready) begin
        if (exp_chars.size() == 0) begin
          check("unexpected_transfer", {24'b0, out_char}, 32'd0);
        end else begin
          check("char", {24'b0, out_char}, {24'b0, exp_chars.pop_front()});
          check("last", {31'b0, out_last}, {31'b0, exp_last.pop_front()});
        end
      end
      if (done) begin
        check("done_valid_low", {31'b0, out_valid}, 32'd0);
        if (exp_count.size() == 0) check("unexpected_done", 32'd1, 32'd0);
        else check("final_count", {{(32-CW){1'b0}}, char_count}, exp_count.pop_front());
      end
      prev_stall = out_valid && !out_ready;
      prev_char  = out_char;
      prev_last  = out_last;
    end
  end

  // Queue the expected emission of a string and return its expected done cycle
  // for the given ready pattern (cycle 1 is the first cycle after the load edge).
  task automatic model_string(input logic [NCHAR*8:1] s, input bit rp [128], output int done_cyc);
    int lastnz = -1;
    int nz = 0;
    int n = 1;
    logic [7:0] b;
    for (int p = 0; p < NCHAR; p++) begin
      b = s[NCHAR*8-8*p -: 8];
      if (b != 8'h00) begin
        lastnz = p;
        nz++;
      end
    end
    for (int p = 0; p < NCHAR; p++) begin
      b = s[NCHAR*8-8*p -: 8];
      if (b != 8'h00) begin
        exp_chars.push_back(b);
        exp_last.push_back(p == lastnz);
        while (!rp[n] && n < 127) n++;
      end
      n++;
    end
    exp_count.push_back(nz);
    done_cyc = n;
  endtask

  // mode 0: ready always; 1: ready low cycles 2-4; 2: random ready;
  // 3: ready always plus a stray load during SEND
  task automatic run_str(input logic [NCHAR*8:1] s, input int mode);
    bit rp [128];
    int exp_done;
    bit seen = 0;
    int n;
    logic [NCHAR*8:1] other;
    for (int i = 0; i < 128; i++) begin
      case (mode)
        1:       rp[i] = !(i >= 2 && i <= 4);
        2:       rp[i] = ($urandom_range(3) != 0);
        default: rp[i] = 1'b1;
      endcase
    end
    model_string(s, rp, exp_done);
    other = {NCHAR{8'h5a}};
    @(posedge clk); #1;
    load = 1'b1; str_in = s;
    @(posedge clk); #1;
    load = 1'b0; str_in = '0;
    for (n = 1; n < 120; n++) begin
      out_ready = rp[n];
      if (mode == 3 && n == 5) begin
        load = 1'b1; str_in = other;
      end else begin
        load = 1'b0;
      end
      if (mode == 1 && n == 3) begin
        check("stall_e_char", {24'b0, out_char}, 32'h65);
        check("stall_e_valid", {31'b0, out_valid}, 32'd1);
        check("stall_e_count", {{(32-CW){1'b0}}, char_count}, 32'd1);
      end
      if (done) begin
        seen = 1;
        break;
      end
      @(posedge clk); #1;
    end
    load = 1'b0;
    if (!seen) check("done_timeout", 32'd0, 32'd1);
    else check("done_cycle", n, exp_done);
    @(posedge clk); #1;
    check("busy_after_done", {31'b0, busy}, 32'd0);
    check("done_one_cycle", {31'b0, done}, 32'd0);
    check("queue_drained", exp_chars.size(), 32'd0);
    out_ready = 1'b1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_valid"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_last"}, {31'b0, out_last}, 32'd0);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_done"}, {31'b0, done}, 32'd0);
    check({tag, "_char"}, {24'b0, out_char}, 32'd0);
    check({tag, "_count"}, {{(32-CW){1'b0}}, char_count}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NCHAR*8:1] s;
    int dummy;
    bit rp_all [128];
    rst = 1'b1; load = 1'b0; str_in = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    rst = 1'b0;

    run_str({"hello world", 16'h0}, 0);
    run_str({"hello world", 16'h0}, 1);
    run_str({8'h00, "ab", 8'h00, "c", 64'h0}, 0);
    run_str('0, 0);
    check("all_null_count", {{(32-CW){1'b0}}, char_count}, 32'd0);
    run_str({"hello world", 16'h0}, 3);
    run_str({"abcdefghijklm"}, 2);

    for (int t = 0; t < 20; t++) begin
      for (int p = 0; p < NCHAR; p++)
        s[NCHAR*8-8*p -: 8] = ($urandom_range(2) == 0) ? 8'h00 : 8'($urandom_range(255, 1));
      run_str(s, (t % 2 == 0) ? 2 : 0);
    end

    // reset mid-stream: abandon the string, no done pulse
    for (int i = 0; i < 128; i++) rp_all[i] = 1'b1;
    model_string({"hello world", 16'h0}, rp_all, dummy);
    @(posedge clk); #1;
    load = 1'b1; str_in = {"hello world", 16'h0};
    @(posedge clk); #1;
    load = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    exp_chars.delete(); exp_last.delete(); exp_count.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    check_quiet("after_rst");
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("no_done_after_rst", {31'b0, done | busy}, 32'd0);
    end

    run_str({"hello world", 16'h0}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/str_byte_sequencer.md
STR_BYTE_SEQUENCER -- requirements
Module: str_byte_sequencer

Interface
REQ-001 The block SHALL have parameter NCHAR, default 13, giving the number of 8-bit character slots in the packed string.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, reset; it is synchronous and active-high.
REQ-004 The block SHALL have port load, input, 1 bit, a request to capture str_in and start emission.
REQ-005 The block SHALL have port str_in, input, [NCHAR*8:1], the packed string; char 0 (first emitted) is in bits [NCHAR*8:NCHAR*8-7]; char NCHAR-1 is in bits [8:1].
REQ-006 The block SHALL have port out_char, output, 8 bits, the current character.
REQ-007 The block SHALL have port out_valid, output, 1 bit, indicating that out_char holds a non-null character.
REQ-008 The block SHALL have port out_ready, input, 1 bit, the consumer accept signal.
REQ-009 The block SHALL have port out_last, output, 1 bit, marking the final non-null character of the string.
REQ-010 The block SHALL have port busy, output, 1 bit, high in states SEND and DONE.
REQ-011 The block SHALL have port done, output, 1 bit, a one-cycle end-of-string pulse.
REQ-012 The block SHALL have port char_count, output, [$clog2(NCHAR+1)-1:0], the number of characters transferred for the current or last string.

Function
REQ-013 The block SHALL implement a state machine with states IDLE, SEND and DONE, plus an internal string register and a position pointer ptr (0..NCHAR-1).
REQ-014 In IDLE with load=1, the block SHALL capture str_in on the edge, set ptr=0 and char_count=0, and enter SEND; there is no wait state.
REQ-015 The block SHALL ignore load while in SEND or DONE; the captured string and ptr are unaffected.
REQ-016 In SEND, out_char SHALL equal the stored byte at ptr; out_valid SHALL be high iff that byte != 8'h00.
REQ-017 A null byte (8'h00) at any position (leading, embedded or trailing) SHALL be skipped: it takes one cycle with out_valid=0, then ptr increments; null bytes are never emitted.
REQ-018 A transfer occurs when out_valid and out_ready are both high; on a transfer ptr increments and char_count increments by 1.
REQ-019 While out_valid=1 and out_ready=0, out_char, out_last and ptr SHALL hold; out_valid SHALL not drop until the transfer occurs.
REQ-020 out_last SHALL be high iff out_valid=1 and every stored byte at positions > ptr is 8'h00.
REQ-021 When position NCHAR-1 completes (transfer, or skip if null), the block SHALL go to DONE instead of incrementing ptr.
REQ-022 DONE SHALL last exactly one cycle with done=1 and out_valid=0, then the block SHALL return to IDLE.
REQ-023 char_count SHALL hold its final value from DONE until the next accepted load.
REQ-024 An all-null string SHALL produce no transfers, NCHAR skip cycles, then a done pulse with char_count=0.
REQ-025 Outside SEND, out_valid, out_last and done (except in DONE) SHALL be 0, and out_char SHALL be 8'h00.

Reset
REQ-026 With rst=1 on a clock edge, the block SHALL set state=IDLE, ptr=0, char_count=0, the string register to 0, and out_valid, out_last, busy and done to 0, with out_char=8'h00.
REQ-027 Reset SHALL take priority over load and abandon any in-progress string immediately; no done pulse follows.

Verification
REQ-028 Load {"hello world",16'b0} with out_ready=1 at cycle 0: 'h','e','l','l','o',' ','w','o','r','l','d' SHALL transfer in cycles 1-11, with out_last only on 'd'; cycles 12-13 SHALL be null skips; done SHALL pulse at cycle 14 with char_count=11; busy SHALL be 0 at cycle 15.
REQ-029 Same string with out_ready low for 3 cycles while 'e' is presented: 'e' SHALL be held stable with out_valid=1, char_count SHALL stay 1, and done SHALL arrive 3 cycles later (cycle 17).
REQ-030 Load {8'h00,"ab",8'h00,"c",64'b0}: the block SHALL emit only 'a','b','c', with out_last on 'c' and final char_count=3.
REQ-031 Load all zeros: out_valid SHALL never assert; done SHALL pulse at cycle 14 with char_count=0.
REQ-032 Pulse load with a different string during SEND: the output stream SHALL be unchanged; then assert rst mid-stream: the next cycle SHALL show IDLE with all outputs 0 and no done pulse.
